// File: rtl/mc_control_if.sv
// mc_control_if: ready-handshaked unified memory request bus between the control FSM and memory.
interface mc_control_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;
  modport master (output mem_read, mem_write, iord, input mem_ready);
  modport slave (input mem_read, mem_write, iord, output mem_ready);
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM (ADD/SUB, LW, SW, BEQ); define CTRL_JUMP_EN to add JAL/JALR.
module mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_if.master     mem,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             fault,
  output logic             retire,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4, MEM_WR = 4'd5,
    EXEC_R = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JAL = 4'd9, JALR = 4'd10, TRAP = 4'd15
  } state_e;
  state_e state_q, state_d, dec_next;
  logic illegal_q, illegal_d, fault_q, fault_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_r, is_mem, is_br, is_jal, is_jalr, wait_st, tmo_hit;
  logic unused;
  assign unused = ^{alu_zero, instr[24:15], instr[11:7]};
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign is_r = opc == 7'b0110011 && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000);
  assign is_mem = (opc == 7'b0000011 || opc == 7'b0100011) && f3 == 3'b010;
  assign is_br = opc == 7'b1100011 && f3 == 3'b000;
`ifdef CTRL_JUMP_EN
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111 && f3 == 3'b000;
`else
  assign is_jal = 1'b0;
  assign is_jalr = 1'b0;
`endif
  assign dec_next = is_r ? EXEC_R : is_mem ? MEM_ADDR : is_br ? BRANCH :
                    is_jal ? JAL : is_jalr ? JALR : TRAP;
  assign wait_st = state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR;
  // mem_ready in the final waiting cycle still completes the access
  assign tmo_hit = MEM_TIMEOUT != 0 && wait_st && !mem.mem_ready && tmo_q == TW'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    illegal_d = illegal_q;
    fault_d = fault_q;
    mem.mem_read = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord = 1'b0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    wb_sel = 2'b00;
    alusrca = 2'b00;
    alusrcb = 2'b00;
    aluop = 2'b00;
    pcsource = 2'b00;
    retire = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem.mem_read = 1'b1;
          alusrcb = 2'b01;
          ir_write = mem.mem_ready;
          pc_write = mem.mem_ready;
          state_d = mem.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alusrca = 2'b10;
          alusrcb = 2'b10;
          state_d = dec_next;
          illegal_d = illegal_q | (dec_next == TRAP);
        end
        MEM_ADDR: begin
          alusrca = 2'b01;
          alusrcb = 2'b10;
          state_d = opc[5] ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem.mem_read = 1'b1;
          mem.iord = 1'b1;
          state_d = mem.mem_ready ? MEM_WB : MEM_RD;
        end
        MEM_WB: begin
          reg_write = 1'b1;
          wb_sel = 2'b01;
          retire = 1'b1;
          state_d = FETCH;
        end
        MEM_WR: begin
          mem.mem_write = 1'b1;
          mem.iord = 1'b1;
          retire = mem.mem_ready;
          state_d = mem.mem_ready ? FETCH : MEM_WR;
        end
        EXEC_R: begin
          alusrca = 2'b01;
          aluop = 2'b10;
          state_d = R_WB;
        end
        R_WB: begin
          reg_write = 1'b1;
          retire = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          alusrca = 2'b01;
          aluop = 2'b01;
          pc_write_cond = 1'b1;
          pcsource = 2'b01;
          retire = 1'b1;
          state_d = FETCH;
        end
        JAL: begin
          reg_write = 1'b1;
          wb_sel = 2'b10;
          pc_write = 1'b1;
          pcsource = 2'b01;
          retire = 1'b1;
          state_d = FETCH;
        end
        JALR: begin
          alusrca = 2'b01;
          alusrcb = 2'b10;
          reg_write = 1'b1;
          wb_sel = 2'b10;
          pc_write = 1'b1;
          retire = 1'b1;
          state_d = FETCH;
        end
        default: state_d = TRAP;
      endcase
      if (tmo_hit) begin
        state_d = TRAP;
        fault_d = 1'b1;
      end
    end
    tmo_d = (state_d != state_q || mem.mem_ready || !wait_st) ? '0 : tmo_q + 1'b1;
    retired_d = retired_q + CNT_W'(retire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      illegal_q <= 1'b0;
      fault_q <= 1'b0;
      tmo_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
      fault_q <= fault_d;
      tmo_q <= tmo_d;
      retired_q <= retired_d;
    end
  end
  assign state = state_q;
  assign illegal = illegal_q;
  assign fault = fault_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream with a cycle/strobe-count reference model for mc_control.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic alu_zero = 1'b0;
  logic pc_write, pc_write_cond, ir_write, reg_write, illegal, fault, retire;
  logic [1:0] wb_sel, alusrca, alusrcb, aluop, pcsource;
  logic [3:0] state;
  logic [31:0] retired;
  mc_control_if mif ();
  mc_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .instr(instr), .alu_zero(alu_zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource), .state(state), .illegal(illegal),
    .fault(fault), .retire(retire), .retired(retired)
  );
  always #5 clk = ~clk;
`ifdef CTRL_JUMP_EN
  localparam int MAXK = 6;
`else
  localparam int MAXK = 4;
`endif
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ret = '0;
  logic [15:0] seq_last = '0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // kinds: 0 ADD, 1 SUB, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6 JALR; register/immediate fields random
  function automatic logic [31:0] mk(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      0: return {7'h00, r[24:15], 3'b000, r[11:7], 7'b0110011};
      1: return {7'h20, r[24:15], 3'b000, r[11:7], 7'b0110011};
      2: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
      3: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
      4: return {r[31:15], 3'b000, r[11:7], 7'b1100011};
      5: return {r[31:7], 7'b1101111};
      default: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  // memory answers after wf wait cycles on fetch and wm on data accesses
  task automatic run_instr(input int k, input logic [31:0] ins, input int wf, input int wm);
    int cyc = 0, waited = 0, rw = 0, mr = 0, mw = 0, pcc = 0, pw = 0, ret = 0, lim;
    logic [1:0] wbs = 2'b00, pcs = 2'b00;
    logic [15:0] seq = '0;
    bit req;
    bit rr = k < 2, ld = k == 2, st = k == 3, br = k == 4, jp = k >= 5;
    int exp_cyc = ((rr || st) ? 4 : ld ? 5 : 3) + wf + ((ld || st) ? wm : 0);
    instr = ins;
    alu_zero = 1'($urandom);
    while (cyc < 60 && ret == 0) begin
      #1;
      req = mif.mem_read | mif.mem_write;
      lim = mif.iord ? wm : wf;
      mif.mem_ready = req && waited >= lim;
      #1;
      cyc++;
      seq = {seq[11:0], state};
      if (reg_write) begin rw++; wbs = wb_sel; end
      if (mif.mem_read) mr++;
      if (mif.mem_write) mw++;
      if (pc_write_cond) begin pcc++; pcs = pcsource; end
      if (pc_write) pw++;
      if (retire) ret++;
      waited = (req && !mif.mem_ready) ? waited + 1 : 0;
      @(negedge clk);
    end
    mif.mem_ready = 1'b0;
    exp_ret++;
    #1;
    chk("cycles", cyc, exp_cyc);
    chk("retire_pulses", ret, 1);
    chk("reg_write_cycles", rw, (rr || ld || jp) ? 1 : 0);
    chk("wb_sel", wbs, rr ? 0 : ld ? 1 : jp ? 2 : 0);
    chk("mem_read_cycles", mr, 1 + wf + (ld ? 1 + wm : 0));
    chk("mem_write_cycles", mw, st ? 1 + wm : 0);
    chk("pc_write_cond_cycles", pcc, br ? 1 : 0);
    chk("branch_pcsource", pcs, br ? 1 : 0);
    chk("pc_write_cycles", pw, jp ? 2 : 1);
    chk("retired", retired, exp_ret);
    chk("end_state", state, 0);
    chk("no_fault", fault, 0);
    seq_last = seq;
  endtask

  task automatic run_illegal(input logic [31:0] ins, input string tag);
    instr = ins;
    #1 mif.mem_ready = 1'b1;
    @(negedge clk);
    #1 mif.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_state"}, state, 15);
    chk({tag, "_illegal"}, illegal, 1);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_absorb"}, state, 15);
    chk({tag, "_no_req"}, mif.mem_read | mif.mem_write, 0);
    chk({tag, "_retired"}, retired, exp_ret);
    do_reset();
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    #12;
    chk("reset_state", state, 0);
    chk("reset_mem_read", mif.mem_read, 0);
    chk("reset_flags", {illegal, fault}, 0);
    chk("reset_retired", retired, 0);
    do_reset();
    run_instr(0, 32'h002081B3, 0, 0);
    chk("add_states", seq_last, 16'h0167);
    run_instr(4, 32'h00208463, 0, 0);
    chk("beq_states", seq_last, 16'h0018);
    run_instr(2, mk(2), 0, 3);
    run_instr(0, mk(0), 3, 0);
    run_instr(3, mk(3), 1, 3);
    for (int i = 0; i < 24; i++) begin
      int k = $urandom_range(0, MAXK);
      run_instr(k, mk(k), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    instr = mk(2);
    #1 mif.mem_ready = 1'b1;
    @(negedge clk);
    #1 mif.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rd_state", state, 3);
    chk("mid_rd_mem_read", mif.mem_read, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_state", state, 0);
    chk("async_reset_mem_read", mif.mem_read, 0);
    chk("async_reset_retired", retired, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
`ifdef CTRL_JUMP_EN
    run_instr(5, mk(5), 0, 0);
    run_instr(6, mk(6), 0, 0);
`else
    run_illegal(mk(5), "jal_illegal");
`endif
    run_illegal(32'h002091B3, "sll_illegal");
    instr = 32'h002081B3;
    mif.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_before_fault", fault, 0);
    chk("tmo_before_state", state, 0);
    @(negedge clk);
    #1;
    chk("tmo_fault", fault, 1);
    chk("tmo_state", state, 15);
    chk("tmo_not_illegal", illegal, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the RV32I subset core: R-type ADD/SUB, LW, SW and BEQ, with optional JAL/JALR. It replaces the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and writeback over several cycles against a ready-handshaked unified memory, and drives the datapath muxes and write enables. It also detects illegal encodings and memory timeouts, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 16, number of cycles a memory request may wait for mem_ready before trapping; 0 disables the timeout
- CNT_W, 32, width of the retired-instruction counter
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  IR contents; valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write this cycle
- alu_zero  input  1  ALU zero flag
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if alu_zero
- ir_write  output  1  IR and oldPC load
- mem_read / mem_write  output  1 each  memory request strobes
- iord  output  1  memory address: 0=PC, 1=ALUOut
- reg_write  output  1  register file write enable
- wb_sel  output  2  writeback source: 00=ALUOut, 01=MDR, 10=PC (PC+4)
- alusrca  output  2  00=PC, 01=rs1, 10=oldPC
- alusrcb  output  2  00=rs2, 01=const 4, 10=imm
- aluop  output  2  00=add, 01=branch compare (sub), 10=R-type via funct
- pcsource  output  2  00=ALU result, 01=ALUOut
- state  output  4  current state encoding
- illegal  output  1  sticky: unsupported encoding decoded
- fault  output  1  sticky: memory timeout
- retire  output  1  one-cycle pulse on the last cycle of each instruction
- retired  output  CNT_W  retired-instruction count, wraps to 0

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JAL=9, JALR=10, TRAP=15.
- Outputs not listed for a state are 0.
- FETCH
  - Outputs: mem_read=1, iord=0, alusrca=00, alusrcb=01.
  - On mem_ready: ir_write=1, pc_write=1, pcsource=00, go to DECODE. Otherwise stay in FETCH.
- DECODE
  - Outputs: alusrca=10, alusrcb=10, so ALUOut gets oldPC+imm.
  - Next state by opcode and funct fields:
    - 0110011 with funct3=000 and funct7 of 0000000 or 0100000 -> EXEC_R.
    - 0000011 with funct3=010, or 0100011 with funct3=010 -> MEM_ADDR.
    - 1100011 with funct3=000 -> BRANCH.
    - Anything else -> TRAP and set illegal.
- MEM_ADDR
  - Outputs: alusrca=01, alusrcb=10.
  - Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, iord=1; on mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, wb_sel=01, retire=1, go to FETCH.
- MEM_WR: mem_write=1, iord=1; on mem_ready assert retire and go to FETCH.
- EXEC_R: alusrca=01, alusrcb=00, aluop=10, go to R_WB.
- R_WB: reg_write=1, wb_sel=00, retire=1, go to FETCH.
- BRANCH: alusrca=01, alusrcb=00, aluop=01, pc_write_cond=1, pcsource=01, retire=1, go to FETCH.
- TRAP: all strobes 0, absorbing until reset.
- Timeout counter
  - Cleared on entry to FETCH, MEM_RD and MEM_WR, and while mem_ready=1.
  - Increments each waiting cycle.
  - When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT-1 without mem_ready: set fault and go to TRAP next cycle.
  - mem_ready arriving in that same cycle wins: no fault.
- retired increments on every retire pulse and wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore-decoded from the state register, except ir_write, pc_write in FETCH and retire in MEM_WR, which are gated by mem_ready.
- Cycles per instruction with zero-wait memory (mem_ready high on the first request cycle):
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - JAL/JALR: 3
- Each wait cycle on a memory state adds 1 cycle.
- Reset (asynchronous, any state, including mid memory request):
  - state=FETCH, all strobes 0, illegal=0, fault=0, retired=0, timeout counter=0.
  - The first FETCH request is issued in the first cycle after rst_n deasserts.
- illegal and fault never clear except by reset.

## Configuration
- CTRL_JUMP_EN
  - Defined:
    - DECODE also accepts 1101111 -> JAL, and 1100111 with funct3=000 -> JALR.
    - JAL: reg_write=1, wb_sel=10, pc_write=1, pcsource=01, retire=1.
    - JALR: alusrca=01, alusrcb=10, reg_write=1, wb_sel=10, pc_write=1, pcsource=00, retire=1.
    - The JALR target has bit 0 cleared by the datapath.
  - Undefined: both opcodes are illegal and go to TRAP; state codes 9 and 10 are unreachable.

## Test plan
- Reset mid-MEM_RD with mem_ready=0 -> state=0, mem_read=0, retired=0 immediately, before the next clk edge.
- ADD (0x002081B3), mem_ready held 1 -> states 0,1,6,7; reg_write only in cycle 4; retire once; retired=1.
- LW with mem_ready=0 for 3 cycles in MEM_RD -> 8 cycles total; wb_sel=01 during the reg_write cycle.
- BEQ (0x00208463) with alu_zero=1 -> pc_write_cond=1 and pcsource=01 in cycle 3; retired increments.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> fault=1 and state=15 after 4 wait cycles. Repeat with mem_ready=1 on the 4th cycle -> no fault.
- Opcode 1101111:
  - Without CTRL_JUMP_EN -> illegal=1, state=15.
  - With CTRL_JUMP_EN -> 3 cycles, wb_sel=10, pc_write=1.
